// File: rtl/control_decode_buffer.sv
// Buffered MIPS decode stage: decodes fetched words on acceptance and queues the
// decoded control set in a DEPTH-entry FIFO, with a sticky halt and flush.
module control_decode_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter bit          ATOMIC_EN = 1'b1
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [31:0]                instruction,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 ALUop,
    output logic [1:0]                 ALUsrc,
    output logic [1:0]                 RegDest,
    output logic [1:0]                 pcsrc,
    output logic                       WEN,
    output logic                       MemtoReg,
    output logic                       dREN,
    output logic                       dWEN,
    output logic                       datomic,
    output logic                       jal,
    output logic                       extop,
    output logic                       LUI,
    output logic                       BEQ,
    output logic                       branch,
    output logic                       itype,
    output logic                       halt,
    output logic                       illegal,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [4:0]                 shamt,
    output logic [15:0]                immed,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB  = 4'd3,
        ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR  = 4'd7,
        ALU_SLT = 4'd8, ALU_SLTU = 4'd9
    } aluop_t;

    typedef struct packed {
        aluop_t      aluop;
        logic [1:0]  alusrc;
        logic [1:0]  regdest;
        logic [1:0]  pcsrc;
        logic        wen, memtoreg, dren, dwen, datomic, jal, extop;
        logic        lui, beq, branch, itype, halt, illegal;
        logic [4:0]  rs, rt, rd, shamt;
        logic [15:0] immed;
    } entry_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111, OP_LW   = 6'b100011, OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LL    = 6'b110000, OP_SC   = 6'b111000, OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_SLL = 6'b000000, FN_SRL  = 6'b000010, FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_ADDU = 6'b100001, FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011, FN_AND = 6'b100100, FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110, FN_NOR  = 6'b100111, FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    entry_t          mem_q [DEPTH];
    entry_t          dec_c, head_c;
    logic            legal_c, push_c, pop_c;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            halted_q, halted_d;

    // Instruction decode; illegal words keep only the raw fields
    always_comb begin
        dec_c   = '0;
        legal_c = 1'b1;
        case (instruction[31:26])
            OP_RTYPE: begin
                dec_c.regdest = 2'd1;
                dec_c.wen     = 1'b1;
                case (instruction[5:0])
                    FN_ADD, FN_ADDU: dec_c.aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_c.aluop = ALU_SUB;
                    FN_AND:  dec_c.aluop = ALU_AND;
                    FN_OR:   dec_c.aluop = ALU_OR;
                    FN_XOR:  dec_c.aluop = ALU_XOR;
                    FN_NOR:  dec_c.aluop = ALU_NOR;
                    FN_SLT:  dec_c.aluop = ALU_SLT;
                    FN_SLTU: dec_c.aluop = ALU_SLTU;
                    FN_SLL: begin dec_c.aluop = ALU_SLL; dec_c.alusrc = 2'd2; end
                    FN_SRL: begin dec_c.aluop = ALU_SRL; dec_c.alusrc = 2'd2; end
                    FN_JR: begin
                        dec_c.regdest = 2'd0;
                        dec_c.wen     = 1'b0;
                        dec_c.pcsrc   = 2'd3;
                    end
                    default: legal_c = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                dec_c.alusrc = 2'd1;
                dec_c.wen    = 1'b1;
                dec_c.itype  = 1'b1;
                case (instruction[31:26])
                    OP_ADDI, OP_ADDIU: begin dec_c.aluop = ALU_ADD;  dec_c.extop = 1'b1; end
                    OP_SLTI:           begin dec_c.aluop = ALU_SLT;  dec_c.extop = 1'b1; end
                    OP_SLTIU:          begin dec_c.aluop = ALU_SLTU; dec_c.extop = 1'b1; end
                    OP_ANDI:           dec_c.aluop = ALU_AND;
                    OP_ORI:            dec_c.aluop = ALU_OR;
                    default:           dec_c.aluop = ALU_XOR;
                endcase
            end
            OP_LUI: begin dec_c.lui = 1'b1; dec_c.wen = 1'b1; dec_c.itype = 1'b1; end
            OP_LW, OP_LL: begin
                dec_c.dren     = 1'b1;
                dec_c.memtoreg = 1'b1;
                dec_c.wen      = 1'b1;
                dec_c.aluop    = ALU_ADD;
                dec_c.alusrc   = 2'd1;
                dec_c.extop    = 1'b1;
                dec_c.datomic  = (instruction[31:26] == OP_LL);
                if (instruction[31:26] == OP_LL && !ATOMIC_EN) legal_c = 1'b0;
            end
            OP_SW: begin
                dec_c.dwen   = 1'b1;
                dec_c.aluop  = ALU_ADD;
                dec_c.alusrc = 2'd1;
                dec_c.extop  = 1'b1;
            end
            OP_SC: begin
                dec_c.dwen     = 1'b1;
                dec_c.datomic  = 1'b1;
                dec_c.wen      = 1'b1;
                dec_c.memtoreg = 1'b1;
                if (!ATOMIC_EN) legal_c = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                dec_c.branch = 1'b1;
                dec_c.beq    = (instruction[31:26] == OP_BEQ);
                dec_c.aluop  = ALU_SUB;
                dec_c.extop  = 1'b1;
                dec_c.pcsrc  = 2'd1;
            end
            OP_J:    dec_c.pcsrc = 2'd2;
            OP_JAL: begin
                dec_c.pcsrc   = 2'd2;
                dec_c.jal     = 1'b1;
                dec_c.wen     = 1'b1;
                dec_c.regdest = 2'd2;
            end
            OP_HALT: dec_c.halt = 1'b1;
            default: legal_c = 1'b0;
        endcase
        if (!legal_c) begin
            dec_c         = '0;
            dec_c.illegal = 1'b1;
        end
        dec_c.rs    = instruction[25:21];
        dec_c.rt    = instruction[20:16];
        dec_c.rd    = instruction[15:11];
        dec_c.shamt = instruction[10:6];
        dec_c.immed = instruction[15:0];
    end

    assign instr_ready = (count_q != CW'(DEPTH)) && !halted_q;
    assign out_valid   = (count_q != '0);
    assign push_c      = instr_valid && instr_ready && !flush;
    assign pop_c       = out_valid && out_ready && !flush;

    // Pointer/count/halt next state; flush discards same-cycle push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        halted_d = halted_q || (push_c && dec_c.halt);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Entry storage needs no reset: the head is masked while empty
    always_ff @(posedge CLK) begin
        if (push_c) mem_q[wr_ptr_q] <= dec_c;
    end

    assign head_c   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign ALUop    = head_c.aluop;
    assign ALUsrc   = head_c.alusrc;
    assign RegDest  = head_c.regdest;
    assign pcsrc    = head_c.pcsrc;
    assign WEN      = head_c.wen;
    assign MemtoReg = head_c.memtoreg;
    assign dREN     = head_c.dren;
    assign dWEN     = head_c.dwen;
    assign datomic  = head_c.datomic;
    assign jal      = head_c.jal;
    assign extop    = head_c.extop;
    assign LUI      = head_c.lui;
    assign BEQ      = head_c.beq;
    assign branch   = head_c.branch;
    assign itype    = head_c.itype;
    assign halt     = head_c.halt;
    assign illegal  = head_c.illegal;
    assign rs       = head_c.rs;
    assign rt       = head_c.rt;
    assign rd       = head_c.rd;
    assign shamt    = head_c.shamt;
    assign immed    = head_c.immed;
    assign count    = count_q;

endmodule
